// File: rtl/gpr_wb_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | gpr_wb_arbiter: shares the GPR write port between pipeline writeback   |
// | (A) and a FIFO-buffered long-op unit (B), with a busy scoreboard.      |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module gpr_wb_arbiter #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        a_valid,
  input  logic [4:0]  a_wr,
  input  logic [31:0] a_din,
  output logic        a_hold,
  input  logic        b_valid,
  output logic        b_ready,
  input  logic [4:0]  b_wr,
  input  logic [31:0] b_din,
  input  logic        iss_valid,
  input  logic [4:0]  iss_wr,
  input  logic [4:0]  chk_ra,
  input  logic [4:0]  chk_rb,
  output logic        stall,
  output logic        en,
  output logic [4:0]  wr,
  output logic [31:0] din,
  output logic [31:0] busy
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [4:0]    fifo_wr  [DEPTH];
  logic [31:0]   fifo_din [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic [1:0]    lose_cnt;

  logic          fifo_ne;
  logic          push;
  logic          pop;
  logic [4:0]    sel_wr;
  logic [31:0]   sel_din;
  logic [PW-1:0] rd_ptr_nx;
  logic [PW-1:0] wr_ptr_nx;
  logic [31:0]   busy_next;

  // Readiness depends only on the registered count: a pop never frees a slot same-cycle.
  assign b_ready   = !rst && (count < CW'(DEPTH));
  assign fifo_ne   = (count != '0);
  assign push      = b_valid && b_ready;
  assign pop       = !a_valid && fifo_ne;
  assign sel_wr    = a_valid ? a_wr  : fifo_wr[rd_ptr];
  assign sel_din   = a_valid ? a_din : fifo_din[rd_ptr];
  assign rd_ptr_nx = (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
  assign wr_ptr_nx = (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);

  assign stall = ((chk_ra != 5'd0) && busy[chk_ra]) ||
                 ((chk_rb != 5'd0) && busy[chk_rb]);

  // A new issue to the register being retired keeps it busy (set wins).
  always_comb begin
    busy_next = busy;
    if (pop && (fifo_wr[rd_ptr] != 5'd0)) busy_next[fifo_wr[rd_ptr]] = 1'b0;
    if (iss_valid && (iss_wr != 5'd0)) busy_next[iss_wr] = 1'b1;
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_wr[wr_ptr]  <= b_wr;
      fifo_din[wr_ptr] <= b_din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      en       <= 1'b0;
      wr       <= 5'd0;
      din      <= 32'd0;
      busy     <= 32'd0;
      a_hold   <= 1'b0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      lose_cnt <= 2'd0;
    end else begin
      if (a_valid || pop) begin
        en  <= (sel_wr != 5'd0);
        wr  <= sel_wr;
        din <= sel_din;
      end else begin
        en  <= 1'b0;
      end
      busy <= busy_next;
      if (push) wr_ptr <= wr_ptr_nx;
      if (pop)  rd_ptr <= rd_ptr_nx;
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      // Third consecutive loss of a waiting B entry asks the pipeline for one idle slot.
      a_hold <= 1'b0;
      if (a_valid && fifo_ne) begin
        if (lose_cnt == 2'd2) begin
          a_hold   <= 1'b1;
          lose_cnt <= 2'd0;
        end else begin
          lose_cnt <= lose_cnt + 2'd1;
        end
      end else begin
        lose_cnt <= 2'd0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_gpr_wb_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_gpr_wb_arbiter: vector table for directed cases, then a queue-based |
// | scoreboard for randomized B traffic mixed with A writes.               |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module tb_gpr_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_valid;
  logic [4:0]  a_wr;
  logic [31:0] a_din;
  logic        a_hold;
  logic        b_valid;
  logic        b_ready;
  logic [4:0]  b_wr;
  logic [31:0] b_din;
  logic        iss_valid;
  logic [4:0]  iss_wr;
  logic [4:0]  chk_ra;
  logic [4:0]  chk_rb;
  logic        stall;
  logic        en;
  logic [4:0]  wr;
  logic [31:0] din;
  logic [31:0] busy;

  int checks = 0;
  int passed = 0;

  gpr_wb_arbiter #(.DEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_wr(a_wr), .a_din(a_din), .a_hold(a_hold),
    .b_valid(b_valid), .b_ready(b_ready), .b_wr(b_wr), .b_din(b_din),
    .iss_valid(iss_valid), .iss_wr(iss_wr),
    .chk_ra(chk_ra), .chk_rb(chk_rb), .stall(stall),
    .en(en), .wr(wr), .din(din), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        r;
    logic        av;
    logic [4:0]  aw;
    logic [31:0] ad;
    logic        bv;
    logic [4:0]  bw;
    logic [31:0] bd;
    logic        iv;
    logic [4:0]  iw;
    logic [4:0]  ra;
    logic [4:0]  rb;
    logic        x_ready;
    logic        x_stall;
    logic        x_en;
    logic [4:0]  x_wr;
    logic [31:0] x_din;
    logic [31:0] x_busy;
    logic        x_hold;
  } vec_t;

  typedef struct packed {
    logic [4:0]  w;
    logic [31:0] d;
  } bwr_t;

  vec_t vecs[$];
  bwr_t sb[$];

  function automatic vec_t mk(
    input logic r, input logic av, input logic [4:0] aw, input logic [31:0] ad,
    input logic bv, input logic [4:0] bw, input logic [31:0] bd,
    input logic iv, input logic [4:0] iw, input logic [4:0] ra, input logic [4:0] rb,
    input logic xr, input logic xs, input logic xe, input logic [4:0] xw,
    input logic [31:0] xd, input logic [31:0] xb, input logic xh);
    vec_t v;
    v.r = r; v.av = av; v.aw = aw; v.ad = ad; v.bv = bv; v.bw = bw; v.bd = bd;
    v.iv = iv; v.iw = iw; v.ra = ra; v.rb = rb;
    v.x_ready = xr; v.x_stall = xs; v.x_en = xe; v.x_wr = xw; v.x_din = xd;
    v.x_busy = xb; v.x_hold = xh;
    return v;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s[%0d]: got %h, expected %h", nm, idx, act, exp);
  endtask

  localparam logic [31:0] B9  = 32'h0000_0200;
  localparam logic [31:0] B21 = 32'h0020_0000;

  initial begin
    bwr_t e;
    int   qn;
    logic exp_ready;

    rst = 1'b1; a_valid = 0; a_wr = 0; a_din = 0; b_valid = 0; b_wr = 0; b_din = 0;
    iss_valid = 0; iss_wr = 0; chk_ra = 0; chk_rb = 0;
    @(posedge clk); #1;

    //             r av aw  ad          bv bw  bd          iv iw  ra  rb  rdy st en wr  din         busy     hold
    vecs.push_back(mk(1,0, 0, 32'h0,     1, 7, 32'h77,    0, 0,  0,  0,  0, 0, 0, 0,  32'h0,      32'h0,   0));
    vecs.push_back(mk(1,1, 5, 32'h55,    1, 7, 32'h77,    0, 0,  0,  0,  0, 0, 0, 0,  32'h0,      32'h0,   0));
    vecs.push_back(mk(0,0, 0, 32'h0,     0, 0, 32'h0,     0, 0,  0,  0,  1, 0, 0, 0,  32'h0,      32'h0,   0));
    vecs.push_back(mk(0,1, 5, 32'h1234,  0, 0, 32'h0,     0, 0,  0,  0,  1, 0, 1, 5,  32'h1234,   32'h0,   0));
    vecs.push_back(mk(0,1, 0, 32'hBEEF,  0, 0, 32'h0,     0, 0,  0,  0,  1, 0, 0, 0,  32'hBEEF,   32'h0,   0));
    vecs.push_back(mk(0,0, 0, 32'h0,     0, 0, 32'h0,     0, 0,  0,  0,  1, 0, 0, 0,  32'hBEEF,   32'h0,   0));
    vecs.push_back(mk(0,0, 0, 32'h0,     0, 0, 32'h0,     1, 9,  9,  0,  1, 0, 0, 0,  32'hBEEF,   B9,      0));
    vecs.push_back(mk(0,0, 0, 32'h0,     1, 9, 32'hDEAD,  0, 0,  9,  0,  1, 1, 0, 0,  32'hBEEF,   B9,      0));
    vecs.push_back(mk(0,0, 0, 32'h0,     0, 0, 32'h0,     0, 0,  9,  0,  1, 1, 1, 9,  32'hDEAD,   32'h0,   0));
    vecs.push_back(mk(0,0, 0, 32'h0,     0, 0, 32'h0,     0, 0,  9,  0,  1, 0, 0, 9,  32'hDEAD,   32'h0,   0));
    vecs.push_back(mk(0,0, 0, 32'h0,     0, 0, 32'h0,     1, 9,  0,  0,  1, 0, 0, 9,  32'hDEAD,   B9,      0));
    vecs.push_back(mk(0,0, 0, 32'h0,     1, 9, 32'hD00D,  0, 0,  0,  0,  1, 0, 0, 9,  32'hDEAD,   B9,      0));
    vecs.push_back(mk(0,0, 0, 32'h0,     0, 0, 32'h0,     1, 9,  9,  0,  1, 1, 1, 9,  32'hD00D,   B9,      0));
    vecs.push_back(mk(0,0, 0, 32'h0,     0, 0, 32'h0,     0, 0,  0,  9,  1, 1, 0, 9,  32'hD00D,   B9,      0));
    vecs.push_back(mk(0,1, 1, 32'h11,    1, 3, 32'h33,    0, 0,  0,  0,  1, 0, 1, 1,  32'h11,     B9,      0));
    vecs.push_back(mk(0,1, 2, 32'h22,    1, 4, 32'h44,    0, 0,  0,  0,  1, 0, 1, 2,  32'h22,     B9,      0));
    vecs.push_back(mk(0,1, 6, 32'h66,    1, 8, 32'h88,    0, 0,  0,  0,  0, 0, 1, 6,  32'h66,     B9,      0));
    vecs.push_back(mk(0,0, 0, 32'h0,     1, 8, 32'h88,    0, 0,  0,  0,  0, 0, 1, 3,  32'h33,     B9,      0));
    vecs.push_back(mk(0,0, 0, 32'h0,     0, 0, 32'h0,     0, 0,  0,  0,  1, 0, 1, 4,  32'h44,     B9,      0));
    vecs.push_back(mk(0,0, 0, 32'h0,     0, 0, 32'h0,     0, 0,  0,  0,  1, 0, 0, 4,  32'h44,     B9,      0));
    vecs.push_back(mk(0,0, 0, 32'h0,     1,10, 32'hAA,    0, 0,  0,  0,  1, 0, 0, 4,  32'h44,     B9,      0));
    vecs.push_back(mk(0,1,11, 32'hB1,    0, 0, 32'h0,     0, 0,  0,  0,  1, 0, 1, 11, 32'hB1,     B9,      0));
    vecs.push_back(mk(0,1,12, 32'hB2,    0, 0, 32'h0,     0, 0,  0,  0,  1, 0, 1, 12, 32'hB2,     B9,      0));
    vecs.push_back(mk(0,1,13, 32'hB3,    0, 0, 32'h0,     0, 0,  0,  0,  1, 0, 1, 13, 32'hB3,     B9,      1));
    vecs.push_back(mk(0,0, 0, 32'h0,     0, 0, 32'h0,     0, 0,  0,  0,  1, 0, 1, 10, 32'hAA,     B9,      0));
    vecs.push_back(mk(0,0, 0, 32'h0,     1,14, 32'hC4,    0, 0,  0,  0,  1, 0, 0, 10, 32'hAA,     B9,      0));
    vecs.push_back(mk(0,1,15, 32'hF1,    0, 0, 32'h0,     0, 0,  0,  0,  1, 0, 1, 15, 32'hF1,     B9,      0));
    vecs.push_back(mk(0,1,16, 32'hF2,    0, 0, 32'h0,     0, 0,  0,  0,  1, 0, 1, 16, 32'hF2,     B9,      0));
    vecs.push_back(mk(0,1,17, 32'hF3,    0, 0, 32'h0,     0, 0,  0,  0,  1, 0, 1, 17, 32'hF3,     B9,      1));
    vecs.push_back(mk(0,1,18, 32'hF4,    0, 0, 32'h0,     0, 0,  0,  0,  1, 0, 1, 18, 32'hF4,     B9,      0));
    vecs.push_back(mk(0,1,19, 32'hF5,    0, 0, 32'h0,     0, 0,  0,  0,  1, 0, 1, 19, 32'hF5,     B9,      0));
    vecs.push_back(mk(0,1,20, 32'hF6,    0, 0, 32'h0,     0, 0,  0,  0,  1, 0, 1, 20, 32'hF6,     B9,      1));
    vecs.push_back(mk(0,0, 0, 32'h0,     0, 0, 32'h0,     0, 0,  0,  0,  1, 0, 1, 14, 32'hC4,     B9,      0));
    vecs.push_back(mk(0,0, 0, 32'h0,     1,21, 32'h21,    1,21,  0,  0,  1, 0, 0, 14, 32'hC4,     B9|B21,  0));
    vecs.push_back(mk(1,0, 0, 32'h0,     0, 0, 32'h0,     0, 0,  0,  0,  0, 0, 0, 0,  32'h0,      32'h0,   0));
    vecs.push_back(mk(0,0, 0, 32'h0,     0, 0, 32'h0,     0, 0, 21,  0,  1, 0, 0, 0,  32'h0,      32'h0,   0));
    vecs.push_back(mk(0,0, 0, 32'h0,     0, 0, 32'h0,     0, 0, 21,  0,  1, 0, 0, 0,  32'h0,      32'h0,   0));

    foreach (vecs[i]) begin
      rst = vecs[i].r; a_valid = vecs[i].av; a_wr = vecs[i].aw; a_din = vecs[i].ad;
      b_valid = vecs[i].bv; b_wr = vecs[i].bw; b_din = vecs[i].bd;
      iss_valid = vecs[i].iv; iss_wr = vecs[i].iw; chk_ra = vecs[i].ra; chk_rb = vecs[i].rb;
      #1;
      chk("b_ready", i, 32'(b_ready), 32'(vecs[i].x_ready));
      chk("stall",   i, 32'(stall),   32'(vecs[i].x_stall));
      @(posedge clk); #1;
      chk("en",      i, 32'(en),      32'(vecs[i].x_en));
      chk("wr",      i, 32'(wr),      32'(vecs[i].x_wr));
      chk("din",     i, din,          vecs[i].x_din);
      chk("busy",    i, busy,         vecs[i].x_busy);
      chk("a_hold",  i, 32'(a_hold),  32'(vecs[i].x_hold));
    end

    // Randomized B traffic with interleaved A writes; B writes must retire in push order.
    rst = 0; iss_valid = 0; iss_wr = 0; chk_ra = 0; chk_rb = 0;
    for (int c = 0; c < 220; c++) begin
      if (c < 200) begin
        a_valid = ($urandom_range(0, 3) == 0);
        b_valid = ($urandom_range(0, 4) < 3);
      end else begin
        a_valid = 1'b0;
        b_valid = 1'b0;
      end
      a_wr  = 5'($urandom_range(1, 31));
      a_din = $urandom;
      b_wr  = 5'($urandom_range(1, 31));
      b_din = $urandom;
      qn = sb.size();
      exp_ready = (qn < 2);
      #1;
      chk("sb_b_ready", c, 32'(b_ready), 32'(exp_ready));
      if (b_valid && exp_ready) begin
        e.w = b_wr; e.d = b_din;
        sb.push_back(e);
      end
      @(posedge clk); #1;
      if (a_valid) begin
        chk("sb_a_en",  c, 32'(en), 32'd1);
        chk("sb_a_wr",  c, 32'(wr), 32'(a_wr));
        chk("sb_a_din", c, din,     a_din);
      end else if (qn > 0) begin
        e = sb.pop_front();
        chk("sb_b_en",  c, 32'(en), 32'd1);
        chk("sb_b_wr",  c, 32'(wr), 32'(e.w));
        chk("sb_b_din", c, din,     e.d);
      end else begin
        chk("sb_idle_en", c, 32'(en), 32'd0);
      end
    end
    chk("sb_drained", 0, 32'(sb.size()), 32'd0);
    chk("sb_busy",    0, busy,           32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
`default_nettype wire
